// File: rtl/gpio_pkg.sv
// Shared types and constants for the GPIO port responder and its input conditioner.
package gpio_pkg;

  localparam int GPIO_WIDTH     = 8;
  localparam int GPIO_DB_CYCLES = 1000;

  // Output-side handshake phases: idle, request held high, waiting for ack to fall.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_LOW = 2'd2
  } gpio_out_state_t;

endpackage : gpio_pkg

// File: rtl/gpio_debounce.sv
// Input conditioner: two-flop synchroniser, then a per-byte debounce that accepts
// a new value only after it has been sampled unchanged for DB_CYCLES cycles.
module gpio_debounce
  import gpio_pkg::*;
#(
  parameter int WIDTH     = GPIO_WIDTH,
  parameter int DB_CYCLES = GPIO_DB_CYCLES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] pad_i,
  output logic [WIDTH-1:0] gpio_i_o,
  output logic             in_change_o
);

  localparam int                CNT_W   = $clog2(DB_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DB_CYCLES - 1);

  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [WIDTH-1:0] cand_q, cand_d;
  logic [WIDTH-1:0] gpio_q, gpio_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             change_q, change_d;

  always_comb begin
    // NOTE: every output of this block is given a default first so that no path
    // through the if/else leaves a signal unassigned, which would infer a latch.
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    gpio_d   = gpio_q;
    change_d = 1'b0;
    if (sync2_q != cand_q) begin
      cand_d = sync2_q;
      cnt_d  = '0;
    end else if (cnt_q == CNT_MAX && cand_q != gpio_q) begin
      gpio_d   = cand_q;
      change_d = 1'b1;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      cand_q   <= '0;
      cnt_q    <= '0;
      gpio_q   <= '0;
      change_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make sync2_q take the old sync1_q, giving
      // the two-stage synchroniser; blocking here would collapse it to one flop.
      sync1_q  <= pad_i;
      sync2_q  <= sync1_q;
      cand_q   <= cand_d;
      cnt_q    <= cnt_d;
      gpio_q   <= gpio_d;
      change_q <= change_d;
    end
  end

  assign gpio_i_o    = gpio_q;
  assign in_change_o = change_q;

endmodule : gpio_debounce

// File: rtl/gpio_port_responder.sv
// External-side partner of the CPU GPIO port: debounced pad inputs towards the CPU,
// and CPU output changes handed to an external consumer over a four-phase req/ack.
module gpio_port_responder
  import gpio_pkg::*;
#(
  parameter int WIDTH     = GPIO_WIDTH,
  parameter int DB_CYCLES = GPIO_DB_CYCLES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] pad_i,
  output logic [WIDTH-1:0] gpio_i_o,
  output logic             in_change_o,
  input  logic [WIDTH-1:0] cpu_gpio_i,
  output logic [WIDTH-1:0] pad_o,
  output logic             out_req_o,
  input  logic             out_ack_i,
  output logic             overrun_o,
  input  logic             overrun_clr_i
);

  gpio_debounce #(
    .WIDTH     (WIDTH),
    .DB_CYCLES (DB_CYCLES)
  ) u_debounce (
    .clk         (clk),
    .reset       (reset),
    .pad_i       (pad_i),
    .gpio_i_o    (gpio_i_o),
    .in_change_o (in_change_o)
  );

  gpio_out_state_t  state_q;
  logic [WIDTH-1:0] pad_q;
  logic [WIDTH-1:0] cpu_prev_q;
  logic             req_q;
  logic             overrun_q;
  logic             cpu_changed;
  logic             busy;

  assign cpu_changed = (cpu_gpio_i != cpu_prev_q);
  assign busy        = (state_q != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      pad_q      <= '0;
      cpu_prev_q <= '0;
      req_q      <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      cpu_prev_q <= cpu_gpio_i;

      // A CPU change during a handshake is dropped; set beats a same-cycle clear.
      if (busy && cpu_changed) begin
        overrun_q <= 1'b1;
      end else if (overrun_clr_i) begin
        overrun_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (cpu_gpio_i != pad_q) begin
            pad_q   <= cpu_gpio_i;
            req_q   <= 1'b1;
            state_q <= REQ;
          end
        end
        REQ: begin
          if (out_ack_i) begin
            req_q   <= 1'b0;
            state_q <= WAIT_LOW;
          end
        end
        WAIT_LOW: begin
          if (!out_ack_i) begin
            state_q <= IDLE;
          end
        end
        default: begin
          req_q   <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign pad_o     = pad_q;
  assign out_req_o = req_q;
  assign overrun_o = overrun_q;

endmodule : gpio_port_responder

// File: tb/tb_gpio_port_responder.sv
// Self-checking bench: directed scenarios plus randomized traffic, checked every
// cycle against a run-length / transaction-level reference model.
module tb_gpio_port_responder;

  localparam int W  = 8;
  localparam int DB = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] pad_i = 8'hFF;
  logic [W-1:0] cpu_gpio_i = 8'h00;
  logic         out_ack_i = 1'b0;
  logic         overrun_clr_i = 1'b0;
  logic [W-1:0] gpio_i_o;
  logic         in_change_o;
  logic [W-1:0] pad_o;
  logic         out_req_o;
  logic         overrun_o;

  gpio_port_responder #(
    .WIDTH     (W),
    .DB_CYCLES (DB)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .pad_i         (pad_i),
    .gpio_i_o      (gpio_i_o),
    .in_change_o   (in_change_o),
    .cpu_gpio_i    (cpu_gpio_i),
    .pad_o         (pad_o),
    .out_req_o     (out_req_o),
    .out_ack_i     (out_ack_i),
    .overrun_o     (overrun_o),
    .overrun_clr_i (overrun_clr_i)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  bit seen_11  = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model. Input side: pad samples reach the debouncer through a
  // two-deep delay line; the byte is accepted once the same synchronised value
  // has been seen on DB+1 consecutive edges. Output side: a transaction is
  // "open" from launch until ack has been seen high and then low again.
  logic [W-1:0] sync_line[$] = '{8'h00, 8'h00};
  logic [W-1:0] run_val = 8'h00;
  int           run_len = 1;
  logic [W-1:0] m_gpio = 8'h00;
  logic         m_change = 1'b0;
  logic [W-1:0] m_pad = 8'h00;
  logic [W-1:0] m_prev = 8'h00;
  logic         m_req = 1'b0;
  logic         m_open = 1'b0;
  logic         m_ovr = 1'b0;

  task automatic model_reset();
    sync_line = '{8'h00, 8'h00};
    run_val   = 8'h00;
    run_len   = 1;
    m_gpio    = 8'h00;
    m_change  = 1'b0;
    m_pad     = 8'h00;
    m_prev    = 8'h00;
    m_req     = 1'b0;
    m_open    = 1'b0;
    m_ovr     = 1'b0;
  endtask

  task automatic model_step();
    logic [W-1:0] s;
    s = sync_line.pop_front();
    sync_line.push_back(pad_i);
    if (s == run_val) begin
      if (run_len <= DB) run_len++;
    end else begin
      run_val = s;
      run_len = 1;
    end
    m_change = 1'b0;
    if (run_len > DB && run_val != m_gpio) begin
      m_gpio   = run_val;
      m_change = 1'b1;
    end

    if (m_open && cpu_gpio_i != m_prev) m_ovr = 1'b1;
    else if (overrun_clr_i)             m_ovr = 1'b0;
    if (!m_open) begin
      if (cpu_gpio_i != m_pad) begin
        m_pad  = cpu_gpio_i;
        m_req  = 1'b1;
        m_open = 1'b1;
      end
    end else if (m_req) begin
      if (out_ack_i) m_req = 1'b0;
    end else if (!out_ack_i) begin
      m_open = 1'b0;
    end
    m_prev = cpu_gpio_i;
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) model_reset();
    else       model_step();
  end

  task automatic compare_all();
    check("gpio_i_o", gpio_i_o, m_gpio);
    check("in_change_o", in_change_o, m_change);
    check("pad_o", pad_o, m_pad);
    check("out_req_o", out_req_o, m_req);
    check("overrun_o", overrun_o, m_ovr);
    if (out_req_o && pad_o == 8'h11) seen_11 = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic count_pulses(input int n, output int first, output int pulses);
    first  = 0;
    pulses = 0;
    for (int i = 1; i <= n; i++) begin
      tick();
      if (in_change_o) begin
        pulses++;
        if (first == 0) first = i;
      end
    end
  endtask

  task automatic ack_cycle();
    out_ack_i = 1'b1;
    tick();
    out_ack_i = 1'b0;
    tick();
  endtask

  int first_edge;
  int n_pulses;

  initial begin
    // Reset with inputs held at pad=FF, cpu=00.
    #1;
    check("rst_gpio", gpio_i_o, 8'h00);
    check("rst_change", in_change_o, 1'b0);
    check("rst_pad", pad_o, 8'h00);
    check("rst_req", out_req_o, 1'b0);
    check("rst_ovr", overrun_o, 1'b0);
    ticks(3);
    reset = 1'b0;
    count_pulses(12, first_edge, n_pulses);
    check("rst_accept_edge", first_edge, 7);
    check("rst_accept_pulses", n_pulses, 1);
    check("rst_accept_val", gpio_i_o, 8'hFF);
    check("rst_no_req", out_req_o, 1'b0);

    // Debounce: clean change, then a too-short glitch.
    pad_i = 8'h00;
    ticks(10);
    pad_i = 8'hA5;
    count_pulses(12, first_edge, n_pulses);
    check("db_accept_edge", first_edge, 7);
    check("db_accept_pulses", n_pulses, 1);
    check("db_accept_val", gpio_i_o, 8'hA5);
    pad_i = 8'hA4;
    ticks(3);
    pad_i = 8'hA5;
    count_pulses(12, first_edge, n_pulses);
    check("db_glitch_pulses", n_pulses, 0);
    check("db_glitch_val", gpio_i_o, 8'hA5);

    // Handshake.
    cpu_gpio_i = 8'h3C;
    tick();
    check("hs_req", out_req_o, 1'b1);
    check("hs_pad", pad_o, 8'h3C);
    ticks(2);
    out_ack_i = 1'b1;
    tick();
    check("hs_req_drop", out_req_o, 1'b0);
    out_ack_i = 1'b0;
    ticks(5);
    check("hs_no_rereq", out_req_o, 1'b0);

    // Overrun: intermediate 0x11 dropped, 0x55 sent afterwards.
    cpu_gpio_i = 8'h00;
    tick();
    ack_cycle();
    cpu_gpio_i = 8'h3C;
    tick();
    seen_11 = 1'b0;
    cpu_gpio_i = 8'h11;
    tick();
    cpu_gpio_i = 8'h55;
    tick();
    check("ovr_set", overrun_o, 1'b1);
    check("ovr_pad_held", pad_o, 8'h3C);
    ack_cycle();
    tick();
    check("ovr_new_req", out_req_o, 1'b1);
    check("ovr_new_pad", pad_o, 8'h55);
    ack_cycle();
    tick();
    check("ovr_no_0x11", seen_11, 1'b0);
    overrun_clr_i = 1'b1;
    tick();
    overrun_clr_i = 1'b0;
    check("ovr_clear", overrun_o, 1'b0);

    // Set and clear in the same cycle: set wins.
    cpu_gpio_i = 8'h77;
    tick();
    cpu_gpio_i    = 8'h78;
    overrun_clr_i = 1'b1;
    tick();
    overrun_clr_i = 1'b0;
    check("sim_set_wins", overrun_o, 1'b1);
    ack_cycle();
    tick();
    ack_cycle();
    tick();
    overrun_clr_i = 1'b1;
    tick();
    overrun_clr_i = 1'b0;

    // Reset in the middle of a request.
    cpu_gpio_i = 8'h3C;
    tick();
    cpu_gpio_i = 8'h40;
    tick();
    cpu_gpio_i = 8'h3C;
    tick();
    check("mid_pre_req", out_req_o, 1'b1);
    check("mid_pre_pad", pad_o, 8'h3C);
    check("mid_pre_ovr", overrun_o, 1'b1);
    reset = 1'b1;
    #1;
    check("mid_rst_req", out_req_o, 1'b0);
    check("mid_rst_pad", pad_o, 8'h00);
    check("mid_rst_ovr", overrun_o, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    tick();
    check("mid_rel_req", out_req_o, 1'b1);
    check("mid_rel_pad", pad_o, 8'h3C);

    // Randomized traffic with an auto-responding consumer.
    for (int i = 0; i < 3000; i++) begin
      tick();
      reset = 1'b0;
      case ($urandom_range(15))
        0, 1:    pad_i = 8'($urandom);
        2:       pad_i = pad_i ^ (8'h01 << $urandom_range(7));
        default: ;
      endcase
      if ($urandom_range(5) == 0) cpu_gpio_i = 8'($urandom);
      overrun_clr_i = ($urandom_range(9) == 0);
      if (out_req_o && !out_ack_i && $urandom_range(2) == 0) out_ack_i = 1'b1;
      else if (!out_req_o && out_ack_i && $urandom_range(2) == 0) out_ack_i = 1'b0;
      if ($urandom_range(499) == 0) reset = 1'b1;
    end
    reset = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_gpio_port_responder

// File: doc/gpio_port_responder.md
Name: gpio_port_responder

Overview:
- External-side partner of the CPU's 8-bit GPIO interface.
- Input path: conditions raw pad inputs (2-FF synchroniser plus debounce) into the stable byte the datapath samples on GPIO_i, and flags each change.
- Output path: watches the datapath's GPIO_o register, drives the new value to the pads, and hands it off to an external consumer with a four-phase req/ack handshake, flagging overruns.

Parameters:
- WIDTH, 8, GPIO byte width for both directions.
- DB_CYCLES, 1000, number of stable sampled cycles required before an input change is accepted. Must be >= 2.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- pad_i  in  WIDTH  raw, asynchronous external inputs (switches/pins).
- gpio_i_o  out  WIDTH  debounced input byte, fed to the datapath GPIO_i.
- in_change_o  out  1  one-cycle pulse when gpio_i_o updates.
- cpu_gpio_i  in  WIDTH  datapath GPIO_o register value.
- pad_o  out  WIDTH  value presented to the external consumer.
- out_req_o  out  1  four-phase request; pad_o is stable while it is high.
- out_ack_i  in  1  consumer acknowledge; treated as synchronous to clk.
- overrun_o  out  1  sticky: the CPU changed its output while a handshake was in progress.
- overrun_clr_i  in  1  synchronous clear of overrun_o.

Behaviour:
- Reset (async, any cycle, including mid-handshake): all of the following clear to 0 immediately:
  - sync1, sync2, cand, cnt, gpio_i_o, in_change_o
  - pad_o, out_req_o, overrun_o, cpu_prev
  - FSM returns to IDLE
  - Because the datapath GPIO_o also resets to 0, no request follows reset.
- Input path, per clock edge:
  - sync1 <= pad_i; sync2 <= sync1.
  - If sync2 != cand: cand <= sync2, cnt <= 0.
  - Else if cnt == DB_CYCLES-1 and cand != gpio_i_o: gpio_i_o <= cand, in_change_o <= 1 for one cycle.
  - Else cnt increments, saturating at DB_CYCLES-1.
  - in_change_o is 0 in every other cycle.
- Input latency: a pad change set up before edge 1 and held steady appears on gpio_i_o after edge 3+DB_CYCLES.
  - Any bit toggle before acceptance restarts the count.
  - A pulse shorter than DB_CYCLES samples is never seen.
  - cnt width is clog2(DB_CYCLES).
- Output FSM states: IDLE, REQ, WAIT_LOW.
  - cpu_prev <= cpu_gpio_i every cycle.
  - IDLE: if cpu_gpio_i != pad_o, then pad_o <= cpu_gpio_i, out_req_o <= 1, go to REQ. Latency is 1 edge.
  - REQ: hold pad_o and out_req_o. If out_ack_i = 1, then out_req_o <= 0 and go to WAIT_LOW.
  - WAIT_LOW: if out_ack_i = 0, go to IDLE.
  - A pending mismatch is launched on the next IDLE edge, so there is a minimum one-cycle IDLE gap between requests.
- Overrun:
  - In REQ or WAIT_LOW, cpu_gpio_i != cpu_prev sets overrun_o.
  - Intermediate values are dropped; only the latest CPU value is sent after the current handshake completes.
  - overrun_clr_i clears overrun_o; a set condition in the same cycle wins.
- pad_o never changes while out_req_o = 1 or while in WAIT_LOW.

Decomposition:
- Package gpio_pkg holds:
  - typedef gpio_out_state_t {IDLE, REQ, WAIT_LOW}
  - constant GPIO_WIDTH = 8
- Sub-module gpio_debounce (WIDTH, DB_CYCLES) contains the synchroniser, cand/cnt logic, gpio_i_o and in_change_o.
- The top level instantiates gpio_debounce and contains the output FSM.

Test Plan (DB_CYCLES=4):
- Reset: hold pad_i=0xFF and cpu_gpio_i=0x00, assert reset -> all outputs 0. After release -> gpio_i_o=0xFF exactly 7 edges later, with a single in_change_o pulse.
- Debounce: pad_i 0x00 -> 0xA5 held -> gpio_i_o=0xA5 at edge 7 with one pulse. Then a glitch to 0xA4 for 3 cycles and back -> gpio_i_o stays 0xA5, no pulse.
- Handshake: cpu_gpio_i 0x00 -> 0x3C -> next edge pad_o=0x3C, out_req_o=1. Ack high 2 cycles later -> out_req_o=0 next edge. Ack low -> IDLE, and no further req while cpu_gpio_i stays 0x3C.
- Overrun: while in REQ, cpu_gpio_i changes 0x3C -> 0x11 -> 0x55 -> overrun_o=1 and pad_o stays 0x3C. After the handshake completes, pad_o=0x55 with a new req; 0x11 is never presented. overrun_clr_i -> overrun_o=0.
- Simultaneous: overrun_clr_i asserted in the same cycle a new overrun occurs -> overrun_o=1.
- Reset mid-REQ: assert reset with out_req_o=1 and pad_o=0x3C -> out_req_o, pad_o and overrun_o drop to 0 immediately. After release with cpu_gpio_i=0x3C -> a new req starts one edge later.
